// File: rtl/eth_axi_pkg.sv
// ---------------------------------------------------------------------------
// eth_axi_pkg
// Shared types for the AXI Ethernet Lite transaction serializer:
//   - write/read FSM state encodings
//   - AXI response codes
//   - default AXI4 request/response structs (4-bit ID, 32-bit addr/data)
// No ports (package).
// ---------------------------------------------------------------------------
package eth_axi_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned USER_W = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_BUSY}         rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [2:0]        prot;
        logic [USER_W-1:0] user;
    } eth_ax_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
        logic [USER_W-1:0]   user;
    } eth_w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } eth_b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } eth_r_chan_t;

    typedef struct packed {
        eth_ax_chan_t aw;
        logic         aw_valid;
        eth_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        eth_ax_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } eth_axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        eth_b_chan_t b;
        logic        r_valid;
        eth_r_chan_t r;
    } eth_axi_rsp_t;

endpackage

// File: rtl/eth_axi_txn_serializer_watchdog.sv
// ---------------------------------------------------------------------------
// eth_axi_watchdog
// Per-direction hang detector. The counter clears when a transaction starts
// or makes progress, and counts while the transaction is active. `fire` is
// a single-cycle pulse when the count reaches Limit-1 without progress; the
// owning FSM aborts on it, which drops `active` and ends the pulse.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   start         transaction accepted this cycle
//   active        transaction waiting on the IP
//   progress      handshake on the awaited channel this cycle
//   fire          timeout pulse
// ---------------------------------------------------------------------------
module eth_axi_watchdog #(
    parameter int unsigned Limit = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    input  logic active,
    input  logic progress,
    output logic fire
);

    localparam int unsigned CntW = (Limit > 2) ? $clog2(Limit) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(Limit - 1);

    logic [CntW-1:0] count_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i || start || progress) begin
            count_reg <= '0;
        end else if (active && (count_reg != LastCount)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign fire = active && !progress && !start && (count_reg == LastCount);

endmodule

// File: rtl/eth_axi_txn_serializer.sv
// ---------------------------------------------------------------------------
// eth_axi_txn_serializer
// AXI4 stage in front of the Xilinx AXI Ethernet Lite slave. Allows one
// write and one read in flight (independently), latches AW/AR IDs and
// echoes them on B/R, forces IDs toward the IP to 0, zeroes user fields
// toward the SoC and masks addresses into the IP window.
// Optional watchdog (macro ETH_AXI_TIMEOUT_EN): hung transactions are
// completed with SLVERR and late IP responses are drained.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   slv_req_i/o    request from / response to the CDC
//   mst_req_o/i    request to / response from the Ethernet IP
//   wr_busy_o      write in flight
//   rd_busy_o      read in flight
//   timeout_o      one-cycle watchdog pulse (0 without the macro)
// ---------------------------------------------------------------------------
module eth_axi_txn_serializer
    import eth_axi_pkg::*;
#(
    parameter type         axi_req_t     = eth_axi_req_t,
    parameter type         axi_rsp_t     = eth_axi_rsp_t,
    parameter int unsigned IdWidth       = 4,
    parameter logic [31:0] AddrMask      = 32'h0000_1FFF,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  axi_req_t slv_req_i,
    output axi_rsp_t slv_rsp_o,
    output axi_req_t mst_req_o,
    input  axi_rsp_t mst_rsp_i,
    output logic     wr_busy_o,
    output logic     rd_busy_o,
    output logic     timeout_o
);

    wr_state_e            wr_state_reg;
    rd_state_e            rd_state_reg;
    logic [IdWidth-1:0]   wr_id_reg, rd_id_reg;
    logic                 b_held_reg;      // B captured from the IP (early or forced error)
    logic [1:0]           b_resp_reg;
    logic                 wr_sink_reg;     // aborted write: swallow remaining W beats
    logic                 wr_drain_reg;    // aborted write: IP still owes a B
    logic                 rd_abort_reg;    // aborted read: emit synthetic SLVERR beat
    logic                 rd_drain_reg;    // aborted read: IP may still send R beats
    logic                 wr_fire, rd_fire;
    logic                 aw_hs, w_hs, slv_b_hs, mst_b_hs, ar_hs, slv_r_hs, mst_r_hs;

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw.id    = '0;
        mst_req_o.aw.addr  = slv_req_i.aw.addr & AddrMask;
        mst_req_o.ar.id    = '0;
        mst_req_o.ar.addr  = slv_req_i.ar.addr & AddrMask;
        mst_req_o.aw_valid = (wr_state_reg == W_IDLE) && slv_req_i.aw_valid;
        mst_req_o.w_valid  = (wr_state_reg == W_DATA) && !wr_sink_reg && slv_req_i.w_valid;
        // Early B is taken while data is still flowing; the pass-through
        // path is used only when nothing is held.
        mst_req_o.b_ready  = wr_drain_reg
                          || ((wr_state_reg == W_DATA) && !b_held_reg)
                          || ((wr_state_reg == W_RESP) && !b_held_reg && slv_req_i.b_ready);
        mst_req_o.ar_valid = (rd_state_reg == R_IDLE) && slv_req_i.ar_valid;
        mst_req_o.r_ready  = rd_drain_reg
                          || ((rd_state_reg == R_BUSY) && !rd_abort_reg && slv_req_i.r_ready);

        slv_rsp_o          = '0;
        slv_rsp_o.aw_ready = (wr_state_reg == W_IDLE) && mst_rsp_i.aw_ready;
        slv_rsp_o.w_ready  = (wr_state_reg == W_DATA) && (wr_sink_reg || mst_rsp_i.w_ready);
        slv_rsp_o.b_valid  = (wr_state_reg == W_RESP)
                          && (b_held_reg || (mst_rsp_i.b_valid && !wr_drain_reg));
        slv_rsp_o.b.id     = wr_id_reg;
        slv_rsp_o.b.resp   = b_held_reg ? b_resp_reg : mst_rsp_i.b.resp;
        slv_rsp_o.ar_ready = (rd_state_reg == R_IDLE) && mst_rsp_i.ar_ready;
        slv_rsp_o.r_valid  = (rd_state_reg == R_BUSY)
                          && (rd_abort_reg || (mst_rsp_i.r_valid && !rd_drain_reg));
        slv_rsp_o.r.id     = rd_id_reg;
        slv_rsp_o.r.data   = rd_abort_reg ? '0 : mst_rsp_i.r.data;
        slv_rsp_o.r.resp   = rd_abort_reg ? RESP_SLVERR : mst_rsp_i.r.resp;
        slv_rsp_o.r.last   = rd_abort_reg || mst_rsp_i.r.last;
    end

    assign aw_hs    = slv_req_i.aw_valid && slv_rsp_o.aw_ready;
    assign w_hs     = slv_req_i.w_valid  && slv_rsp_o.w_ready;
    assign slv_b_hs = slv_rsp_o.b_valid  && slv_req_i.b_ready;
    assign mst_b_hs = mst_rsp_i.b_valid  && mst_req_o.b_ready;
    assign ar_hs    = slv_req_i.ar_valid && slv_rsp_o.ar_ready;
    assign slv_r_hs = slv_rsp_o.r_valid  && slv_req_i.r_ready;
    assign mst_r_hs = mst_rsp_i.r_valid  && mst_req_o.r_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_reg <= W_IDLE;
            wr_id_reg    <= '0;
            b_held_reg   <= 1'b0;
            b_resp_reg   <= RESP_OKAY;
            wr_sink_reg  <= 1'b0;
            wr_drain_reg <= 1'b0;
        end else begin
            if (wr_drain_reg && mst_b_hs) wr_drain_reg <= 1'b0;
            case (wr_state_reg)
                W_IDLE: if (aw_hs) begin
                    wr_id_reg    <= slv_req_i.aw.id;
                    wr_state_reg <= W_DATA;
                end
                W_DATA: begin
                    if (mst_b_hs && !wr_drain_reg) begin
                        b_held_reg <= 1'b1;
                        b_resp_reg <= mst_rsp_i.b.resp;
                    end
                    if (wr_fire) begin
                        wr_sink_reg  <= 1'b1;
                        b_held_reg   <= 1'b1;
                        b_resp_reg   <= RESP_SLVERR;
                        wr_drain_reg <= !(b_held_reg || (mst_b_hs && !wr_drain_reg));
                    end
                    if (w_hs && slv_req_i.w.last) wr_state_reg <= W_RESP;
                end
                W_RESP: begin
                    if (wr_fire) begin
                        b_held_reg   <= 1'b1;
                        b_resp_reg   <= RESP_SLVERR;
                        wr_drain_reg <= 1'b1;
                    end
                    if (slv_b_hs) begin
                        wr_state_reg <= W_IDLE;
                        b_held_reg   <= 1'b0;
                        wr_sink_reg  <= 1'b0;
                    end
                end
                default: wr_state_reg <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state_reg <= R_IDLE;
            rd_id_reg    <= '0;
            rd_abort_reg <= 1'b0;
            rd_drain_reg <= 1'b0;
        end else begin
            if (rd_drain_reg && mst_r_hs && mst_rsp_i.r.last) rd_drain_reg <= 1'b0;
            case (rd_state_reg)
                R_IDLE: if (ar_hs) begin
                    rd_id_reg    <= slv_req_i.ar.id;
                    rd_state_reg <= R_BUSY;
                end
                R_BUSY: begin
                    if (rd_fire) begin
                        rd_abort_reg <= 1'b1;
                        rd_drain_reg <= 1'b1;
                    end
                    if (slv_r_hs && slv_rsp_o.r.last) begin
                        rd_state_reg <= R_IDLE;
                        rd_abort_reg <= 1'b0;
                    end
                end
                default: rd_state_reg <= R_IDLE;
            endcase
        end
    end

`ifdef ETH_AXI_TIMEOUT_EN
    logic wr_wd_active, rd_wd_active;
    assign wr_wd_active = ((wr_state_reg == W_DATA) && !wr_sink_reg)
                       || ((wr_state_reg == W_RESP) && !b_held_reg);
    assign rd_wd_active = (rd_state_reg == R_BUSY) && !rd_abort_reg;

    eth_axi_watchdog #(.Limit(TimeoutCycles)) u_wr_wd (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start    (aw_hs),
        .active   (wr_wd_active),
        .progress (w_hs || mst_b_hs),
        .fire     (wr_fire)
    );

    eth_axi_watchdog #(.Limit(TimeoutCycles)) u_rd_wd (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start    (ar_hs),
        .active   (rd_wd_active),
        .progress (slv_r_hs),
        .fire     (rd_fire)
    );

    assign timeout_o = wr_fire || rd_fire;
`else
    logic unused_cfg;
    assign unused_cfg = (TimeoutCycles >= 2);
    assign wr_fire    = 1'b0;
    assign rd_fire    = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    assign wr_busy_o = (wr_state_reg != W_IDLE);
    assign rd_busy_o = (rd_state_reg != R_IDLE);

    // The IP's ID and user fields carry no meaning here.
    logic unused_rsp;
    assign unused_rsp = ^{mst_rsp_i.b.id, mst_rsp_i.b.user, mst_rsp_i.r.id, mst_rsp_i.r.user};

endmodule

// File: tb/tb_eth_axi_txn_serializer.sv
// ---------------------------------------------------------------------------
// tb_eth_axi_txn_serializer
// Directed bench: drives both AXI sides directly, pushes expected B/R beats
// into scoreboard queues when the request is issued and pops them when the
// serializer presents the response. Timeout scenario is included when
// ETH_AXI_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_eth_axi_txn_serializer;
    import eth_axi_pkg::*;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    logic         clk = 1'b0;
    logic         rst;
    eth_axi_req_t slv_req, mst_req;
    eth_axi_rsp_t slv_rsp, mst_rsp;
    logic         wr_busy, rd_busy, timeout;
    int           vectors = 0;
    int           miscompares = 0;
    int           mst_w_beats = 0;
    b_exp_t       b_q[$];
    r_exp_t       r_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && mst_req.w_valid && mst_rsp.w_ready) mst_w_beats++;

    eth_axi_txn_serializer #(.TimeoutCycles(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .slv_req_i (slv_req),
        .slv_rsp_o (slv_rsp),
        .mst_req_o (mst_req),
        .mst_rsp_i (mst_rsp),
        .wr_busy_o (wr_busy),
        .rd_busy_o (rd_busy),
        .timeout_o (timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_b(input string tag);
        b_exp_t e;
        int n = 0;
        while (!slv_rsp.b_valid && n < 50) begin step(); n++; end
        chk({tag, " b_valid"}, 64'(slv_rsp.b_valid), 64'd1);
        chk({tag, " b_pending"}, 64'(b_q.size() != 0), 64'd1);
        if (b_q.size() != 0) begin
            e = b_q.pop_front();
            chk({tag, " b_id"}, 64'(slv_rsp.b.id), 64'(e.id));
            chk({tag, " b_resp"}, 64'(slv_rsp.b.resp), 64'(e.resp));
            chk({tag, " b_user"}, 64'(slv_rsp.b.user), 64'd0);
        end
        $display("txn B  id=%0h resp=%0h", slv_rsp.b.id, slv_rsp.b.resp);
    endtask

    task automatic expect_r(input string tag);
        r_exp_t e;
        int n = 0;
        while (!slv_rsp.r_valid && n < 50) begin step(); n++; end
        chk({tag, " r_valid"}, 64'(slv_rsp.r_valid), 64'd1);
        chk({tag, " r_pending"}, 64'(r_q.size() != 0), 64'd1);
        if (r_q.size() != 0) begin
            e = r_q.pop_front();
            chk({tag, " r_id"}, 64'(slv_rsp.r.id), 64'(e.id));
            chk({tag, " r_data"}, 64'(slv_rsp.r.data), 64'(e.data));
            chk({tag, " r_resp"}, 64'(slv_rsp.r.resp), 64'(e.resp));
            chk({tag, " r_last"}, 64'(slv_rsp.r.last), 64'(e.last));
            chk({tag, " r_user"}, 64'(slv_rsp.r.user), 64'd0);
        end
        $display("txn R  id=%0h data=%h resp=%0h last=%0b", slv_rsp.r.id, slv_rsp.r.data,
                 slv_rsp.r.resp, slv_rsp.r.last);
    endtask

    task automatic w_beat(input logic [31:0] data, input logic last);
        slv_req.w.data  = data;
        slv_req.w.strb  = 4'hF;
        slv_req.w.last  = last;
        slv_req.w_valid = 1'b1;
        step();
        slv_req.w_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        slv_req = '0;
        mst_rsp = '0;
        step(); step();
        chk("reset busy/timeout", 64'({wr_busy, rd_busy, timeout}), 64'd0);
        chk("reset mst valid/ready", 64'({mst_req.aw_valid, mst_req.w_valid, mst_req.b_ready,
                                          mst_req.ar_valid, mst_req.r_ready}), 64'd0);
        chk("reset slv ready/valid", 64'({slv_rsp.aw_ready, slv_rsp.w_ready, slv_rsp.b_valid,
                                          slv_rsp.ar_ready, slv_rsp.r_valid}), 64'd0);
        rst = 1'b0;
        mst_rsp.aw_ready = 1'b1;
        mst_rsp.w_ready  = 1'b1;
        mst_rsp.ar_ready = 1'b1;
        slv_req.b_ready  = 1'b1;

        // Single write
        slv_req.aw.id = 4'hA; slv_req.aw.addr = 32'h8000_07F4; slv_req.aw.len = 8'd0;
        slv_req.aw.size = 3'd2; slv_req.aw.burst = 2'b01; slv_req.aw_valid = 1'b1;
        b_q.push_back('{id: 4'hA, resp: RESP_OKAY});
        settle();
        chk("t1 mst awaddr", 64'(mst_req.aw.addr), 64'h0000_07F4);
        chk("t1 mst awid", 64'(mst_req.aw.id), 64'd0);
        chk("t1 mst awvalid", 64'(mst_req.aw_valid), 64'd1);
        chk("t1 slv awready", 64'(slv_rsp.aw_ready), 64'd1);
        step();
        slv_req.aw_valid = 1'b0;
        chk("t1 wr_busy", 64'(wr_busy), 64'd1);
        slv_req.w.data = 32'hCAFE_0001; slv_req.w.strb = 4'hF; slv_req.w.last = 1'b1;
        slv_req.w_valid = 1'b1;
        settle();
        chk("t1 mst wvalid", 64'(mst_req.w_valid), 64'd1);
        chk("t1 mst wdata", 64'(mst_req.w.data), 64'hCAFE_0001);
        step();
        slv_req.w_valid = 1'b0;
        mst_rsp.b_valid = 1'b1; mst_rsp.b.resp = RESP_OKAY; mst_rsp.b.id = 4'h5; mst_rsp.b.user = 1'b1;
        settle();
        expect_b("t1");
        step();
        mst_rsp.b_valid = 1'b0;
        settle();
        chk("t1 wr idle", 64'(wr_busy), 64'd0);

        // Back-to-back AW: second held off until first B handshakes
        slv_req.aw.id = 4'h1; slv_req.aw_valid = 1'b1;
        b_q.push_back('{id: 4'h1, resp: RESP_OKAY});
        step();
        slv_req.aw.id = 4'h2;
        b_q.push_back('{id: 4'h2, resp: RESP_SLVERR});
        settle();
        chk("t2 aw blocked data", 64'(slv_rsp.aw_ready), 64'd0);
        w_beat(32'h1111_0000, 1'b1);
        settle();
        chk("t2 aw blocked resp", 64'(slv_rsp.aw_ready), 64'd0);
        mst_rsp.b_valid = 1'b1; mst_rsp.b.resp = RESP_OKAY;
        settle();
        expect_b("t2 first");
        chk("t2 aw blocked b cycle", 64'(slv_rsp.aw_ready), 64'd0);
        step();
        mst_rsp.b_valid = 1'b0;
        settle();
        chk("t2 aw ready after b", 64'(slv_rsp.aw_ready), 64'd1);
        step();
        slv_req.aw_valid = 1'b0;
        w_beat(32'h2222_0000, 1'b1);
        mst_rsp.b_valid = 1'b1; mst_rsp.b.resp = RESP_SLVERR;
        settle();
        expect_b("t2 second");
        step();
        mst_rsp.b_valid = 1'b0;

        // Read burst with a stalled AR and a concurrent write
        slv_req.ar.id = 4'h3; slv_req.ar.addr = 32'hFFFF_E010; slv_req.ar.len = 8'd3;
        slv_req.ar_valid = 1'b1;
        for (int k = 0; k < 4; k++)
            r_q.push_back('{id: 4'h3, data: 32'hD000_0000 + 32'(k), resp: RESP_OKAY, last: (k == 3)});
        settle();
        chk("t3 mst araddr", 64'(mst_req.ar.addr), 64'h0000_0010);
        chk("t3 mst arid", 64'(mst_req.ar.id), 64'd0);
        chk("t3 mst arlen", 64'(mst_req.ar.len), 64'd3);
        step();
        slv_req.ar.id = 4'h5; slv_req.ar.len = 8'd0;
        settle();
        chk("t3 ar blocked", 64'(slv_rsp.ar_ready), 64'd0);
        chk("t3 rd_busy", 64'(rd_busy), 64'd1);
        slv_req.aw.id = 4'h7; slv_req.aw_valid = 1'b1;
        b_q.push_back('{id: 4'h7, resp: RESP_OKAY});
        step();
        slv_req.aw_valid = 1'b0;
        w_beat(32'h7777_0000, 1'b1);
        mst_rsp.b_valid = 1'b1; mst_rsp.b.resp = RESP_OKAY;
        settle();
        expect_b("t3 write");
        step();
        mst_rsp.b_valid = 1'b0;
        settle();
        chk("t3 busy pair", 64'({wr_busy, rd_busy}), 64'b01);
        slv_req.r_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mst_rsp.r_valid = 1'b1; mst_rsp.r.data = 32'hD000_0000 + 32'(k);
            mst_rsp.r.last = (k == 3); mst_rsp.r.id = 4'hF; mst_rsp.r.resp = RESP_OKAY;
            mst_rsp.r.user = 1'b1;
            settle();
            expect_r("t3 burst");
            chk("t3 ar stalled", 64'(slv_rsp.ar_ready), 64'd0);
            step();
        end
        mst_rsp.r_valid = 1'b0;
        settle();
        chk("t3 ar after rlast", 64'(slv_rsp.ar_ready), 64'd1);
        r_q.push_back('{id: 4'h5, data: 32'h0000_0055, resp: RESP_OKAY, last: 1'b1});
        step();
        slv_req.ar_valid = 1'b0;
        mst_rsp.r_valid = 1'b1; mst_rsp.r.data = 32'h0000_0055; mst_rsp.r.last = 1'b1;
        settle();
        expect_r("t3 second read");
        step();
        mst_rsp.r_valid = 1'b0;

        // Early B in the same cycle as wlast
        slv_req.aw.id = 4'h9; slv_req.aw.len = 8'd1; slv_req.aw_valid = 1'b1;
        b_q.push_back('{id: 4'h9, resp: 2'b01});
        step();
        slv_req.aw_valid = 1'b0;
        w_beat(32'h9999_0000, 1'b0);
        slv_req.w.data = 32'h9999_0001; slv_req.w.last = 1'b1; slv_req.w_valid = 1'b1;
        mst_rsp.b_valid = 1'b1; mst_rsp.b.resp = 2'b01;
        slv_req.b_ready = 1'b0;
        settle();
        chk("t4 early b ready", 64'(mst_req.b_ready), 64'd1);
        chk("t4 no slv b yet", 64'(slv_rsp.b_valid), 64'd0);
        step();
        mst_rsp.b_valid = 1'b0; slv_req.w_valid = 1'b0;
        settle();
        chk("t4 held b valid", 64'(slv_rsp.b_valid), 64'd1);
        chk("t4 held blocks ip b", 64'(mst_req.b_ready), 64'd0);
        slv_req.b_ready = 1'b1;
        settle();
        expect_b("t4");
        step();
        chk("t4 wr idle", 64'(wr_busy), 64'd0);
        chk("t4 ip w beats", 64'(mst_w_beats), 64'd6);

        // Reset in the middle of a 4-beat write
        slv_req.aw.id = 4'h4; slv_req.aw.len = 8'd3; slv_req.aw_valid = 1'b1;
        step();
        slv_req.aw_valid = 1'b0;
        w_beat(32'h4444_0000, 1'b0);
        w_beat(32'h4444_0001, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        slv_req.w.last = 1'b0; slv_req.w_valid = 1'b1;
        settle();
        chk("t5 wr_busy", 64'(wr_busy), 64'd0);
        chk("t5 valids", 64'({mst_req.aw_valid, mst_req.w_valid, slv_rsp.b_valid,
                              slv_rsp.r_valid, mst_req.ar_valid}), 64'd0);
        slv_req.w_valid = 1'b0;
        slv_req.aw.id = 4'h6; slv_req.aw.len = 8'd0; slv_req.aw_valid = 1'b1;
        b_q.push_back('{id: 4'h6, resp: RESP_OKAY});
        settle();
        chk("t5 fresh aw ready", 64'(slv_rsp.aw_ready), 64'd1);
        step();
        slv_req.aw_valid = 1'b0;
        w_beat(32'h6666_0000, 1'b1);
        mst_rsp.b_valid = 1'b1; mst_rsp.b.resp = RESP_OKAY;
        settle();
        expect_b("t5");
        step();
        mst_rsp.b_valid = 1'b0;
        settle();
        chk("t5 ip w beats", 64'(mst_w_beats), 64'd9);

`ifdef ETH_AXI_TIMEOUT_EN
        // Hung read: IP never answers
        slv_req.ar.id = 4'hC; slv_req.ar.len = 8'd0; slv_req.ar_valid = 1'b1;
        step();
        slv_req.ar_valid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("t6 timeout c%0d", k), 64'(timeout), 64'(k == 15));
        end
        r_q.push_back('{id: 4'hC, data: 32'd0, resp: RESP_SLVERR, last: 1'b1});
        expect_r("t6 abort");
        step();
        chk("t6 timeout cleared", 64'(timeout), 64'd0);
        chk("t6 rd idle", 64'(rd_busy), 64'd0);
        slv_req.ar.id = 4'hD; slv_req.ar_valid = 1'b1;
        settle();
        chk("t6 new ar ready", 64'(slv_rsp.ar_ready), 64'd1);
        step();
        slv_req.ar_valid = 1'b0;
        mst_rsp.r_valid = 1'b1; mst_rsp.r.data = 32'h0000_0BAD; mst_rsp.r.last = 1'b1;
        mst_rsp.r.resp = RESP_OKAY;
        settle();
        chk("t6 late r hidden", 64'(slv_rsp.r_valid), 64'd0);
        chk("t6 late r drained", 64'(mst_req.r_ready), 64'd1);
        step();
        r_q.push_back('{id: 4'hD, data: 32'h0000_0077, resp: RESP_OKAY, last: 1'b1});
        mst_rsp.r.data = 32'h0000_0077;
        settle();
        expect_r("t6 next read");
        step();
        mst_rsp.r_valid = 1'b0;
`else
        chk("t6 timeout tied", 64'(timeout), 64'd0);
`endif

        chk("end b queue empty", 64'(b_q.size()), 64'd0);
        chk("end r queue empty", 64'(r_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
